// File: rtl/peregrine_pif_reg_slice.sv
// -----------------------------------------------------------------------------
// peregrine_pif_reg_slice
//
// Purpose: fully registered PIF pipeline stage. The request channel (master ->
// slave) and the response channel (slave -> master) are independent 2-entry
// skid slices: an output register plus a skid register. Valid, payload and
// ready are all driven straight from flops, so no input reaches any output
// through combinational logic. Sustains one beat per cycle per channel when
// the far side is continuously ready; latency is one cycle through an empty
// slice. Beats are never inspected, decoded or reordered.
//
// Optional feature macro: PEREGRINE_PIF_SLICE_ROUTE_ID_EN
//   When defined, adds RID_W-bit route-ID ports on both channels, carried in
//   the same registers as the payload. When undefined, those ports and their
//   storage do not exist.
//
// Ports:
//   CLK, Reset                   clock, synchronous active-high reset
//   POReqValid_M / PIReqRdy_M    request handshake, master side (in / out)
//   POReqCntl_M .. Priority_M    request payload from master (in)
//   POReqValid_S / PIReqRdy_S    request handshake, slave side (out / in)
//   POReqCntl_S .. Priority_S    request payload to slave (out)
//   PIRespValid_S / PORespRdy_S  response handshake, slave side (in / out)
//   PIRespCntl_S .. Priority_S   response payload from slave (in)
//   PIRespValid_M / PORespRdy_M  response handshake, master side (out / in)
//   PIRespCntl_M .. Priority_M   response payload to master (out)
// -----------------------------------------------------------------------------

// One channel: EMPTY / ONE / FULL skid slice with registered ready and valid.
module peregrine_pif_slice_chan #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e         state_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic [W-1:0]   out_data_q;
  logic [W-1:0]   skid_q;

  // Handshakes are qualified by our own registered ready/valid only.
  logic accept;
  logic drain;
  assign accept = in_valid_i & in_ready_q;
  assign drain  = out_valid_q & out_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      skid_q      <= '0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          // Ready rises on the first clock after reset releases.
          in_ready_q <= 1'b1;
          if (accept) begin
            out_data_q  <= in_data_i;
            out_valid_q <= 1'b1;
            state_q     <= ST_ONE;
          end
        end
        ST_ONE: begin
          unique case ({accept, drain})
            2'b10: begin
              // Far side stalled: park the new beat in the skid register
              // and stop accepting until the output register drains.
              skid_q     <= in_data_i;
              in_ready_q <= 1'b0;
              state_q    <= ST_FULL;
            end
            2'b11: out_data_q <= in_data_i;
            2'b01: begin
              out_valid_q <= 1'b0;
              state_q     <= ST_EMPTY;
            end
            default: ;
          endcase
        end
        ST_FULL: begin
          // Ready is low here, so no accept can coincide with the drain.
          if (drain) begin
            out_data_q <= skid_q;
            in_ready_q <= 1'b1;
            state_q    <= ST_ONE;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

module peregrine_pif_reg_slice #(
  parameter int RID_W = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  // Request channel, master side
  input  logic             POReqValid_M,
  output logic             PIReqRdy_M,
  input  logic [7:0]       POReqCntl_M,
  input  logic [31:0]      POReqAdrs_M,
  input  logic [31:0]      POReqData_M,
  input  logic [3:0]       POReqDataBE_M,
  input  logic [5:0]       POReqId_M,
  input  logic [1:0]       POReqPriority_M,
  // Request channel, slave side
  output logic             POReqValid_S,
  input  logic             PIReqRdy_S,
  output logic [7:0]       POReqCntl_S,
  output logic [31:0]      POReqAdrs_S,
  output logic [31:0]      POReqData_S,
  output logic [3:0]       POReqDataBE_S,
  output logic [5:0]       POReqId_S,
  output logic [1:0]       POReqPriority_S,
`ifdef PEREGRINE_PIF_SLICE_ROUTE_ID_EN
  input  logic [RID_W-1:0] POReqRouteId_M,
  output logic [RID_W-1:0] POReqRouteId_S,
  input  logic [RID_W-1:0] PIRespRouteId_S,
  output logic [RID_W-1:0] PIRespRouteId_M,
`endif
  // Response channel, slave side
  input  logic             PIRespValid_S,
  output logic             PORespRdy_S,
  input  logic [7:0]       PIRespCntl_S,
  input  logic [31:0]      PIRespData_S,
  input  logic [5:0]       PIRespId_S,
  input  logic [1:0]       PIRespPriority_S,
  // Response channel, master side
  output logic             PIRespValid_M,
  input  logic             PORespRdy_M,
  output logic [7:0]       PIRespCntl_M,
  output logic [31:0]      PIRespData_M,
  output logic [5:0]       PIRespId_M,
  output logic [1:0]       PIRespPriority_M
);

  // Route-ID width is part of the interface contract even when unused.
  if (RID_W < 1) begin : g_rid_w_check
    $error("RID_W must be at least 1");
  end

`ifdef PEREGRINE_PIF_SLICE_ROUTE_ID_EN
  localparam int REQ_W  = 84 + RID_W;
  localparam int RESP_W = 48 + RID_W;
`else
  localparam int REQ_W  = 84;
  localparam int RESP_W = 48;
`endif

  logic [REQ_W-1:0]  req_in;
  logic [REQ_W-1:0]  req_out;
  logic [RESP_W-1:0] resp_in;
  logic [RESP_W-1:0] resp_out;

  // Fields are packed as opaque bits; the slice never looks inside them.
`ifdef PEREGRINE_PIF_SLICE_ROUTE_ID_EN
  assign req_in = {POReqCntl_M, POReqAdrs_M, POReqData_M, POReqDataBE_M,
                   POReqId_M, POReqPriority_M, POReqRouteId_M};
  assign {POReqCntl_S, POReqAdrs_S, POReqData_S, POReqDataBE_S,
          POReqId_S, POReqPriority_S, POReqRouteId_S} = req_out;
  assign resp_in = {PIRespCntl_S, PIRespData_S, PIRespId_S,
                    PIRespPriority_S, PIRespRouteId_S};
  assign {PIRespCntl_M, PIRespData_M, PIRespId_M,
          PIRespPriority_M, PIRespRouteId_M} = resp_out;
`else
  assign req_in = {POReqCntl_M, POReqAdrs_M, POReqData_M, POReqDataBE_M,
                   POReqId_M, POReqPriority_M};
  assign {POReqCntl_S, POReqAdrs_S, POReqData_S, POReqDataBE_S,
          POReqId_S, POReqPriority_S} = req_out;
  assign resp_in = {PIRespCntl_S, PIRespData_S, PIRespId_S, PIRespPriority_S};
  assign {PIRespCntl_M, PIRespData_M, PIRespId_M, PIRespPriority_M} = resp_out;
`endif

  peregrine_pif_slice_chan #(.W(REQ_W)) u_req (
    .clk_i       (CLK),
    .rst_i       (Reset),
    .in_valid_i  (POReqValid_M),
    .in_ready_o  (PIReqRdy_M),
    .in_data_i   (req_in),
    .out_valid_o (POReqValid_S),
    .out_ready_i (PIReqRdy_S),
    .out_data_o  (req_out)
  );

  peregrine_pif_slice_chan #(.W(RESP_W)) u_resp (
    .clk_i       (CLK),
    .rst_i       (Reset),
    .in_valid_i  (PIRespValid_S),
    .in_ready_o  (PORespRdy_S),
    .in_data_i   (resp_in),
    .out_valid_o (PIRespValid_M),
    .out_ready_i (PORespRdy_M),
    .out_data_o  (resp_out)
  );

endmodule

// File: tb/tb_peregrine_pif_reg_slice.sv
module tb_peregrine_pif_reg_slice;

  localparam int RID_W = 4;
`ifdef PEREGRINE_PIF_SLICE_ROUTE_ID_EN
  localparam int REQ_W  = 84 + RID_W;
  localparam int RESP_W = 48 + RID_W;
`else
  localparam int REQ_W  = 84;
  localparam int RESP_W = 48;
`endif

  logic CLK = 1'b0;
  logic Reset = 1'b1;
  always #5 CLK = ~CLK;

  logic             POReqValid_M, PIReqRdy_M, POReqValid_S, PIReqRdy_S;
  logic [7:0]       POReqCntl_M, POReqCntl_S;
  logic [31:0]      POReqAdrs_M, POReqAdrs_S, POReqData_M, POReqData_S;
  logic [3:0]       POReqDataBE_M, POReqDataBE_S;
  logic [5:0]       POReqId_M, POReqId_S;
  logic [1:0]       POReqPriority_M, POReqPriority_S;
  logic             PIRespValid_S, PORespRdy_S, PIRespValid_M, PORespRdy_M;
  logic [7:0]       PIRespCntl_S, PIRespCntl_M;
  logic [31:0]      PIRespData_S, PIRespData_M;
  logic [5:0]       PIRespId_S, PIRespId_M;
  logic [1:0]       PIRespPriority_S, PIRespPriority_M;
`ifdef PEREGRINE_PIF_SLICE_ROUTE_ID_EN
  logic [RID_W-1:0] POReqRouteId_M, POReqRouteId_S, PIRespRouteId_S, PIRespRouteId_M;
`endif

  peregrine_pif_reg_slice #(.RID_W(RID_W)) dut (
    .CLK              (CLK),
    .Reset            (Reset),
    .POReqValid_M     (POReqValid_M),
    .PIReqRdy_M       (PIReqRdy_M),
    .POReqCntl_M      (POReqCntl_M),
    .POReqAdrs_M      (POReqAdrs_M),
    .POReqData_M      (POReqData_M),
    .POReqDataBE_M    (POReqDataBE_M),
    .POReqId_M        (POReqId_M),
    .POReqPriority_M  (POReqPriority_M),
    .POReqValid_S     (POReqValid_S),
    .PIReqRdy_S       (PIReqRdy_S),
    .POReqCntl_S      (POReqCntl_S),
    .POReqAdrs_S      (POReqAdrs_S),
    .POReqData_S      (POReqData_S),
    .POReqDataBE_S    (POReqDataBE_S),
    .POReqId_S        (POReqId_S),
    .POReqPriority_S  (POReqPriority_S),
`ifdef PEREGRINE_PIF_SLICE_ROUTE_ID_EN
    .POReqRouteId_M   (POReqRouteId_M),
    .POReqRouteId_S   (POReqRouteId_S),
    .PIRespRouteId_S  (PIRespRouteId_S),
    .PIRespRouteId_M  (PIRespRouteId_M),
`endif
    .PIRespValid_S    (PIRespValid_S),
    .PORespRdy_S      (PORespRdy_S),
    .PIRespCntl_S     (PIRespCntl_S),
    .PIRespData_S     (PIRespData_S),
    .PIRespId_S       (PIRespId_S),
    .PIRespPriority_S (PIRespPriority_S),
    .PIRespValid_M    (PIRespValid_M),
    .PORespRdy_M      (PORespRdy_M),
    .PIRespCntl_M     (PIRespCntl_M),
    .PIRespData_M     (PIRespData_M),
    .PIRespId_M       (PIRespId_M),
    .PIRespPriority_M (PIRespPriority_M)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [REQ_W-1:0]  req_q[$];
  logic [RESP_W-1:0] resp_q[$];
  int req_pop_cyc[$];
  int resp_acc_cyc[$];
  int resp_pop_cyc[$];

  logic [REQ_W-1:0]  req_obs;
  logic [RESP_W-1:0] resp_obs;
`ifdef PEREGRINE_PIF_SLICE_ROUTE_ID_EN
  assign req_obs  = {POReqCntl_S, POReqAdrs_S, POReqData_S, POReqDataBE_S,
                     POReqId_S, POReqPriority_S, POReqRouteId_S};
  assign resp_obs = {PIRespCntl_M, PIRespData_M, PIRespId_M, PIRespPriority_M,
                     PIRespRouteId_M};
`else
  assign req_obs  = {POReqCntl_S, POReqAdrs_S, POReqData_S, POReqDataBE_S,
                     POReqId_S, POReqPriority_S};
  assign resp_obs = {PIRespCntl_M, PIRespData_M, PIRespId_M, PIRespPriority_M};
`endif

  function automatic logic [REQ_W-1:0] mk_req(input logic [7:0] c, input logic [31:0] a,
                                              input logic [31:0] d, input logic [3:0] be,
                                              input logic [5:0] id, input logic [1:0] pr,
                                              input logic [RID_W-1:0] rid);
    logic [REQ_W+RID_W-1:0] full;
    full = {c, a, d, be, id, pr, rid};
`ifdef PEREGRINE_PIF_SLICE_ROUTE_ID_EN
    return full[REQ_W-1:0];
`else
    return full[REQ_W+RID_W-1:RID_W];
`endif
  endfunction

  function automatic logic [RESP_W-1:0] mk_resp(input logic [7:0] c, input logic [31:0] d,
                                                input logic [5:0] id, input logic [1:0] pr,
                                                input logic [RID_W-1:0] rid);
    logic [RESP_W+RID_W-1:0] full;
    full = {c, d, id, pr, rid};
`ifdef PEREGRINE_PIF_SLICE_ROUTE_ID_EN
    return full[RESP_W-1:0];
`else
    return full[RESP_W+RID_W-1:RID_W];
`endif
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a beat leaves the DUT whenever valid and ready are
  // both high; sampled mid-cycle so the values are settled.
  logic [REQ_W-1:0]  req_exp;
  logic [RESP_W-1:0] resp_exp;
  always @(negedge CLK) begin
    if (!Reset && POReqValid_S && PIReqRdy_S) begin
      req_pop_cyc.push_back(cyc);
      if (req_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL req_unexpected: got %h expected no beat", req_obs);
      end else begin
        req_exp = req_q.pop_front();
        chk("req_beat", 128'(req_obs), 128'(req_exp));
        $display("req  beat cyc %0d: %h", cyc, req_obs);
      end
    end
    if (!Reset && PIRespValid_M && PORespRdy_M) begin
      resp_pop_cyc.push_back(cyc);
      if (resp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected: got %h expected no beat", resp_obs);
      end else begin
        resp_exp = resp_q.pop_front();
        chk("resp_beat", 128'(resp_obs), 128'(resp_exp));
        $display("resp beat cyc %0d: %h", cyc, resp_obs);
      end
    end
  end

  // Drivers: called just after a rising edge; return just after the edge
  // on which the beat was accepted, with valid still asserted.
  task automatic send_req(input logic [REQ_W-1:0] p);
    bit done;
    done = 1'b0;
`ifdef PEREGRINE_PIF_SLICE_ROUTE_ID_EN
    {POReqCntl_M, POReqAdrs_M, POReqData_M, POReqDataBE_M, POReqId_M,
     POReqPriority_M, POReqRouteId_M} = p;
`else
    {POReqCntl_M, POReqAdrs_M, POReqData_M, POReqDataBE_M, POReqId_M,
     POReqPriority_M} = p;
`endif
    POReqValid_M = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge CLK);
      done = PIReqRdy_M;
      @(posedge CLK);
      if (done) req_q.push_back(p);
    end
    chk("req_accept_timeout", 128'(done), 128'(1));
    #1;
  endtask

  task automatic send_resp(input logic [RESP_W-1:0] p);
    bit done;
    int c;
    done = 1'b0;
    c = 0;
`ifdef PEREGRINE_PIF_SLICE_ROUTE_ID_EN
    {PIRespCntl_S, PIRespData_S, PIRespId_S, PIRespPriority_S, PIRespRouteId_S} = p;
`else
    {PIRespCntl_S, PIRespData_S, PIRespId_S, PIRespPriority_S} = p;
`endif
    PIRespValid_S = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge CLK);
      done = PORespRdy_S;
      c = cyc;
      @(posedge CLK);
      if (done) begin
        resp_q.push_back(p);
        resp_acc_cyc.push_back(c);
      end
    end
    chk("resp_accept_timeout", 128'(done), 128'(1));
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    POReqValid_M = 0; POReqCntl_M = 0; POReqAdrs_M = 0; POReqData_M = 0;
    POReqDataBE_M = 0; POReqId_M = 0; POReqPriority_M = 0; PIReqRdy_S = 0;
    PIRespValid_S = 0; PIRespCntl_S = 0; PIRespData_S = 0; PIRespId_S = 0;
    PIRespPriority_S = 0; PORespRdy_M = 0;
`ifdef PEREGRINE_PIF_SLICE_ROUTE_ID_EN
    POReqRouteId_M = 0; PIRespRouteId_S = 0;
`endif
    Reset = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_req_rdy",    128'(PIReqRdy_M),    128'(0));
    chk("rst_resp_rdy",   128'(PORespRdy_S),   128'(0));
    chk("rst_req_valid",  128'(POReqValid_S),  128'(0));
    chk("rst_resp_valid", 128'(PIRespValid_M), 128'(0));
    chk("rst_req_payload", 128'(req_obs),      128'(0));
    @(posedge CLK); #1;
    Reset = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("post_rst_req_rdy",  128'(PIReqRdy_M),  128'(1));
    chk("post_rst_resp_rdy", 128'(PORespRdy_S), 128'(1));
    @(posedge CLK); #1;

    // Single read, latency 1
    PIReqRdy_S = 1'b1;
    send_req(mk_req(8'h00, 32'h6000_0010, 32'h0, 4'hF, 6'h05, 2'd0, 4'h0));
    POReqValid_M = 1'b0;
    @(negedge CLK);
    chk("single_valid", 128'(POReqValid_S), 128'(1));
    chk("single_adrs",  128'(POReqAdrs_S),  128'(32'h6000_0010));
    chk("single_id",    128'(POReqId_S),    128'(6'h05));
    repeat (3) @(posedge CLK); #1;

    // Back-pressure: two absorbed, third held, then released in order
    PIReqRdy_S = 1'b0;
    send_req(mk_req(8'h80, 32'h1000, 32'h11, 4'hF, 6'h01, 2'd0, 4'h0));
    send_req(mk_req(8'h80, 32'h1004, 32'h22, 4'hF, 6'h01, 2'd0, 4'h0));
    fork
      send_req(mk_req(8'h80, 32'h1008, 32'h33, 4'hF, 6'h01, 2'd0, 4'h0));
      begin
        repeat (3) @(negedge CLK);
        chk("bp_rdy_low",   128'(PIReqRdy_M),   128'(0));
        chk("bp_valid",     128'(POReqValid_S), 128'(1));
        chk("bp_head_data", 128'(POReqData_S),  128'(32'h11));
        req_pop_cyc.delete();
        @(posedge CLK); #1;
        PIReqRdy_S = 1'b1;
      end
    join
    POReqValid_M = 1'b0;
    repeat (5) @(posedge CLK); #1;
    chk("bp_beats", 128'(req_pop_cyc.size()), 128'(3));
    if (req_pop_cyc.size() >= 3) begin
      chk("bp_gap0", 128'(req_pop_cyc[1] - req_pop_cyc[0]), 128'(1));
      chk("bp_gap1", 128'(req_pop_cyc[2] - req_pop_cyc[1]), 128'(1));
    end

    // Streaming 16-beat response
    PORespRdy_M = 1'b1;
    resp_acc_cyc.delete();
    resp_pop_cyc.delete();
    for (int i = 0; i < 16; i++)
      send_resp(mk_resp(8'(8'h40 + i), 32'hD000_0000 + 32'(i), 6'h0A, 2'd1, 4'h3));
    PIRespValid_S = 1'b0;
    repeat (4) @(posedge CLK); #1;
    chk("stream_beats", 128'(resp_pop_cyc.size()), 128'(16));
    if (resp_pop_cyc.size() == 16 && resp_acc_cyc.size() == 16) begin
      for (int i = 0; i < 16; i++)
        chk("stream_timing", 128'(resp_pop_cyc[i]), 128'(resp_acc_cyc[0] + 1 + i));
    end

    // Continuous accept + drain: ready never drops
    PIReqRdy_S = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send_req(mk_req(8'h81, 32'h2000 + 32'(4 * i), 32'hA5A5_0000 + 32'(i), 4'h3,
                          6'h07, 2'd2, 4'h0));
      end
      begin
        @(posedge CLK);
        repeat (7) begin
          @(negedge CLK);
          chk("cont_rdy",   128'(PIReqRdy_M),   128'(1));
          chk("cont_valid", 128'(POReqValid_S), 128'(1));
        end
      end
    join
    POReqValid_M = 1'b0;
    repeat (3) @(posedge CLK); #1;

    // Reset in the middle of a stalled burst
    PIReqRdy_S = 1'b0;
    PORespRdy_M = 1'b0;
    send_req(mk_req(8'h82, 32'h3000, 32'hDEAD_0001, 4'hF, 6'h11, 2'd0, 4'h0));
    send_req(mk_req(8'h82, 32'h3004, 32'hDEAD_0002, 4'hF, 6'h11, 2'd0, 4'h0));
    POReqValid_M = 1'b0;
    send_resp(mk_resp(8'h83, 32'hBEEF_0001, 6'h12, 2'd0, 4'h0));
    PIRespValid_S = 1'b0;
    Reset = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("midrst_req_valid",  128'(POReqValid_S),  128'(0));
    chk("midrst_resp_valid", 128'(PIRespValid_M), 128'(0));
    chk("midrst_req_rdy",    128'(PIReqRdy_M),    128'(0));
    req_q.delete();
    resp_q.delete();
    PIReqRdy_S = 1'b1;
    PORespRdy_M = 1'b1;
    @(posedge CLK); #1;
    Reset = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("after_rst_req_rdy",   128'(PIReqRdy_M),    128'(1));
    chk("after_rst_resp_rdy",  128'(PORespRdy_S),   128'(1));
    chk("after_rst_req_valid", 128'(POReqValid_S),  128'(0));
    repeat (5) @(posedge CLK); #1;
    send_req(mk_req(8'h84, 32'h4000, 32'h1234_5678, 4'h1, 6'h2A, 2'd3, 4'h0));
    POReqValid_M = 1'b0;
    repeat (3) @(posedge CLK); #1;

`ifdef PEREGRINE_PIF_SLICE_ROUTE_ID_EN
    // Route ID travels with its beat
    send_req(mk_req(8'h85, 32'h5000, 32'h5555_AAAA, 4'hF, 6'h3F, 2'd1, 4'hA));
    POReqValid_M = 1'b0;
    @(negedge CLK);
    chk("route_req",  128'(POReqRouteId_S), 128'(4'hA));
    chk("route_data", 128'(POReqData_S),    128'(32'h5555_AAAA));
    @(posedge CLK); #1;
    send_resp(mk_resp(8'h86, 32'h7777_0000, 6'h01, 2'd2, 4'h5));
    PIRespValid_S = 1'b0;
    @(negedge CLK);
    chk("route_resp", 128'(PIRespRouteId_M), 128'(4'h5));
    repeat (3) @(posedge CLK); #1;
`endif

    repeat (5) @(posedge CLK); #1;
    chk("req_sb_empty",  128'(req_q.size()),  128'(0));
    chk("resp_sb_empty", 128'(resp_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
